// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and helpers for input-conditioning blocks
package debounce_pkg;

  localparam int DEF_STABLE_TICKS = 20;
  localparam int DEF_SYNC_STAGES  = 2;

  // Counter only has to reach STABLE_TICKS-1; one spare code keeps the width safe for STABLE_TICKS=1.
  function automatic int cnt_width(input int stable_ticks);
    return (stable_ticks < 1) ? 1 : $clog2(stable_ticks + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounced channel: synchroniser, stability counter, edge strobes
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int   SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_data,
  output logic o_data,
  output logic o_rise,
  output logic o_fall
);

  localparam int            CW       = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   data_q, data_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q  <= '0;
      data_q <= RESET_LEVEL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_data};
      cnt_q  <= cnt_d;
      data_q <= data_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // A single matching sample clears the count, so only an unbroken run of differing ticks is accepted.
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync == data_q) begin
      cnt_d = '0;
    end else if (i_tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        data_d = sync;
        rise_d = sync;
        fall_d = ~sync;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign o_data = data_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;

endmodule

// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - array of independent debounce channels sharing one sample tick
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int   CHANNELS     = 4,
  parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int   SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_tick,
  input  logic [CHANNELS-1:0] i_data,
  output logic [CHANNELS-1:0] o_data,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall
);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_ch (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_tick(i_tick),
      .i_data(i_data[n]),
      .o_data(o_data[n]),
      .o_rise(o_rise[n]),
      .o_fall(o_fall[n])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - scoreboard bench for multi_debouncer
module tb_multi_debouncer;

  localparam int CH = 4;
  localparam int ST = 8;
  localparam int SS = 2;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_tick;
  logic [CH-1:0] i_data;
  logic [CH-1:0] o_data;
  logic [CH-1:0] o_rise;
  logic [CH-1:0] o_fall;

  multi_debouncer #(
    .CHANNELS    (CH),
    .STABLE_TICKS(ST),
    .SYNC_STAGES (SS),
    .RESET_LEVEL (1'b0)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_tick(i_tick),
    .i_data(i_data),
    .o_data(o_data),
    .o_rise(o_rise),
    .o_fall(o_fall)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int ch;
    bit rise;
    int edge_no;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   edge_n = 0;
  int   tick_mode = 0;
  int   frz_lo = 0;
  int   frz_hi = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Mode 0: tick every clock. Mode 1: tick on every 4th edge, suppressed inside the freeze window.
  function automatic bit tick_at(input int e);
    if (tick_mode == 0) return 1'b1;
    return (e % 4 == 0) && !(e >= frz_lo && e < frz_hi);
  endfunction

  // Input changed just before edge e0 is visible to the counter from edge e0+SS; acceptance on the ST-th ticked edge.
  function automatic int predict(input int e0);
    int n;
    n = 0;
    for (int e = e0 + SS; e < e0 + 10000; e++) begin
      if (tick_at(e)) begin
        n++;
        if (n == ST) return e;
      end
    end
    return -1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge i_clk);
      i_tick = tick_at(edge_n + 1);
    end
  endtask

  task automatic wait_edge(input int e);
    while (edge_n < e) cyc(1);
  endtask

  task automatic expect_strobe(input int ch, input bit rise, input int e);
    exp_t x;
    x.ch = ch;
    x.rise = rise;
    x.edge_no = e;
    exp_q.push_back(x);
  endtask

  always @(posedge i_clk) begin : monitor
    int k;
    edge_n++;
    #1;
    if (!i_rst && (|(o_rise | o_fall))) begin
      check("rise_fall_exclusive", o_rise & o_fall, 0);
      for (int c = 0; c < CH; c++) begin
        if (o_rise[c] || o_fall[c]) begin
          k = -1;
          foreach (exp_q[j]) if (k < 0 && exp_q[j].ch == c) k = j;
          if (k < 0) begin
            check($sformatf("unexpected_strobe_ch%0d", c), edge_n, -1);
          end else begin
            check($sformatf("strobe_edge_ch%0d", c), edge_n, exp_q[k].edge_no);
            check($sformatf("strobe_dir_ch%0d", c), o_rise[c], exp_q[k].rise);
            check($sformatf("strobe_level_ch%0d", c), o_data[c], exp_q[k].rise);
            exp_q.delete(k);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int e;
    int p;
    int e_last;
    i_rst  = 1'b1;
    i_tick = 1'b1;
    i_data = '0;
    cyc(3);
    check("reset_data", o_data, 0);
    check("reset_rise", o_rise, 0);
    check("reset_fall", o_fall, 0);
    i_rst = 1'b0;
    cyc(2);
    check("idle_data", o_data, 0);

    // Clean step on channel 0
    i_data[0] = 1'b1;
    e = edge_n + 1;
    p = predict(e);
    expect_strobe(0, 1'b1, p);
    wait_edge(p - 1);
    check("step_pre", o_data, 4'b0000);
    cyc(1);
    check("step_data", o_data, 4'b0001);
    check("step_rise", o_rise, 4'b0001);
    cyc(1);
    check("step_rise_one_cycle", o_rise, 4'b0000);

    // Bounce on channel 1: 13 toggles three cycles apart, ending high
    e_last = 0;
    for (int t = 0; t < 13; t++) begin
      i_data[1] = ~i_data[1];
      e_last = edge_n + 1;
      cyc(3);
    end
    check("bounce_no_accept", o_data[1], 0);
    p = predict(e_last);
    expect_strobe(1, 1'b1, p);
    wait_edge(p);
    check("bounce_data", o_data[1], 1);
    check("bounce_rise", o_rise, 4'b0010);

    // Release on channel 2: a 7-cycle low is rejected, an 8-cycle low is accepted
    i_data[2] = 1'b1;
    p = predict(edge_n + 1);
    expect_strobe(2, 1'b1, p);
    wait_edge(p);
    cyc(2);
    i_data[2] = 1'b0;
    cyc(7);
    i_data[2] = 1'b1;
    cyc(12);
    check("glitch7_rejected", o_data[2], 1);
    i_data[2] = 1'b0;
    e = edge_n + 1;
    p = predict(e);
    expect_strobe(2, 1'b0, p);
    wait_edge(p);
    check("release_data", o_data[2], 0);
    check("release_fall", o_fall, 4'b0100);
    cyc(1);
    check("release_fall_one_cycle", o_fall, 4'b0000);

    // Tick gating on channel 3 with a freeze window
    tick_mode = 1;
    e = edge_n + 1;
    frz_lo = e + 12;
    frz_hi = e + 40;
    i_tick = tick_at(e);
    i_data[3] = 1'b1;
    p = predict(e);
    expect_strobe(3, 1'b1, p);
    wait_edge(e + 38);
    check("frozen_hold", o_data[3], 0);
    wait_edge(p - 1);
    check("gated_pre", o_data[3], 0);
    cyc(1);
    check("gated_data", o_data[3], 1);
    tick_mode = 0;
    i_tick = 1'b1;
    cyc(2);

    // Drop channels 0 and 3 together; channel 1 stays high into the reset test
    i_data[0] = 1'b0;
    i_data[3] = 1'b0;
    p = predict(edge_n + 1);
    expect_strobe(0, 1'b0, p);
    expect_strobe(3, 1'b0, p);
    wait_edge(p);
    check("dual_fall", o_fall, 4'b1001);
    check("pre_reset_data", o_data, 4'b0010);

    // Reset while channel 0 has counted 5 differing samples
    i_data[0] = 1'b1;
    e = edge_n + 1;
    wait_edge(e + SS + 4);
    i_rst = 1'b1;
    #1;
    check("midreset_data", o_data, 0);
    check("midreset_rise", o_rise, 0);
    check("midreset_fall", o_fall, 0);
    cyc(2);
    i_rst = 1'b0;
    e = edge_n + 1;
    p = predict(e);
    expect_strobe(0, 1'b1, p);
    expect_strobe(1, 1'b1, p);
    cyc(1);
    check("release_no_strobe", o_rise | o_fall, 0);
    wait_edge(p - 1);
    check("post_reset_pre", o_data, 0);
    cyc(1);
    check("post_reset_rise", o_rise, 4'b0011);

    // All channels low, then a simultaneous step up
    i_data = '0;
    p = predict(edge_n + 1);
    expect_strobe(0, 1'b0, p);
    expect_strobe(1, 1'b0, p);
    wait_edge(p);
    check("all_low", o_data, 0);
    cyc(2);
    i_data = '1;
    p = predict(edge_n + 1);
    for (int c = 0; c < CH; c++) expect_strobe(c, 1'b1, p);
    wait_edge(p);
    check("simul_rise", o_rise, 4'b1111);
    check("simul_data", o_data, 4'b1111);
    cyc(5);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
# multi_debouncer

Parametrised, multi-channel successor to the single-bit switch debouncer. Each channel synchronises an asynchronous input, requires it to hold a new level for a programmable number of sample ticks before accepting it, and emits one-cycle rise/fall strobes on each accepted change. It sits between board-level buttons/switches and control logic, serving every mechanical input from one instance.

## Interface

- `CHANNELS`, 4: number of independent input bits (≥1).
- `STABLE_TICKS`, 20: consecutive differing samples needed to accept a new level (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `RESET_LEVEL`, 1'b0: level loaded into synchronisers and `o_data` at reset.

Ports:

- `i_clk` in 1: single clock; all logic on rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_tick` in 1: sample-enable strobe shared by all channels; tie high for per-clock sampling.
- `i_data` in CHANNELS: raw asynchronous inputs.
- `o_data` out CHANNELS: debounced levels.
- `o_rise` out CHANNELS: one-cycle pulse when `o_data[n]` goes 0→1.
- `o_fall` out CHANNELS: one-cycle pulse when `o_data[n]` goes 1→0.

## Operation

- Per channel: `SYNC_STAGES`-deep synchroniser → `sync[n]`; counter `cnt[n]` of width `$clog2(STABLE_TICKS+1)`; output register `o_data[n]`.
- Every clock, if `sync[n] == o_data[n]`: `cnt[n] <= 0`, regardless of `i_tick`. Any single matching sample cancels a pending change (glitch rejection).
- If `sync[n] != o_data[n]` and `i_tick == 1`:
  - `cnt[n] == STABLE_TICKS-1`: `o_data[n] <= sync[n]`, `cnt[n] <= 0`, pulse `o_rise[n]` or `o_fall[n]` per direction.
  - Otherwise: `cnt[n] <= cnt[n] + 1`.
- If `sync[n] != o_data[n]` and `i_tick == 0`: `cnt[n]` holds.
- The counter never exceeds `STABLE_TICKS-1`. No wrap-around.
- Channels are fully independent. Simultaneous acceptances on several channels all pulse in the same cycle.
- `o_rise[n]` and `o_fall[n]` are never both high.
- Reset (any time, including mid-count):
  - Synchronisers and `o_data` ← `RESET_LEVEL`.
  - `cnt` ← 0.
  - `o_rise`, `o_fall` ← 0.
  - No strobe is generated on reset release, even if `i_data` differs from `RESET_LEVEL`. That difference is debounced normally afterwards.

## Timing

- Strobes are registered and coincide exactly with the cycle `o_data` changes. They last one cycle.
- With `i_tick` tied high, a clean input step sampled first at edge E changes `o_data` at edge E + `SYNC_STAGES` + `STABLE_TICKS` - 1. With the defaults that is 21 edges after E.
- With a divided `i_tick`, latency is `SYNC_STAGES` clocks plus `STABLE_TICKS` tick-qualified mismatching cycles.
- An input pulse shorter than `STABLE_TICKS` ticks (after synchronisation) never reaches `o_data`.
- Outputs depend only on registers. There is no combinational path from `i_data` or `i_tick`.

## Structure

- Package `debounce_pkg`: default constants `DEF_STABLE_TICKS`, `DEF_SYNC_STAGES`, and a `cnt_width(stable_ticks)` function. Shared with future input-conditioning blocks.
- Sub-module `debounce_channel`: one synchroniser, counter and edge logic, with scalar ports plus `i_tick`.
- `multi_debouncer` instantiates `debounce_channel` via a generate loop over `CHANNELS` and contains no other logic.
- Estimated 150–250 lines total.

## Test plan

Bench config: `CHANNELS`=4, `STABLE_TICKS`=8, `SYNC_STAGES`=2, `RESET_LEVEL`=0, `i_tick`=1.

- Clean step: `i_data[0]` 0→1 before edge 10 → `o_data[0]` rises at edge 19; `o_rise[0]`=1 for exactly that cycle; channels 1–3 stay 0.
- Bounce: `i_data[1]` toggles every 3 cycles for 40 cycles, then holds 1 → no strobe during toggling; `o_data[1]`=1 exactly 9 edges after the last toggle, with a single `o_rise[1]`.
- Release: after `o_data[2]`=1, drop `i_data[2]` to 0 for 7 cycles, then 1 → no change. A 0 held for 8+ cycles → `o_fall[2]` pulse, `o_data[2]`=0.
- Tick gating: `i_tick` high 1 cycle in 4; `i_data[3]` 0→1 → `o_data[3]` changes after 2 + 8 ticks; holding `i_tick`=0 freezes `cnt` with no change.
- Reset mid-count: assert `i_rst` while `cnt[0]`=5 with `i_data[0]`=1 → `o_data`=0 and strobes=0 immediately; after release, `o_data[0]` rises 10 edges later with one `o_rise[0]`.
- Simultaneous: all four inputs step 0→1 together → `o_rise`=4'b1111 in a single cycle.
